approx_umult_pipe: RTL and testbench
====================================

Name: approx_umult_pipe

Overview:
- Parametrised, pipelined successor to the fixed 32x32 truncated approximate multipliers.
- Truncation level L is selectable per transaction at run time, from 0 (exact) to LMAX. One compensation term is optional.
- Valid/ready handshake on both sides. Intended for the error-characterisation harness and for datapaths that trade accuracy for power per operation.

Parameters:
- WIDTH, 32, operand width in bits; must be even and >= 8.
- LMAX, 16, maximum truncation level; 4 <= LMAX <= WIDTH/2.
- LW, 5, width of the level field; 2^LW > LMAX.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, request valid.
- in_ready, output, 1, block can accept a request.
- x, input, WIDTH, unsigned multiplicand; its low bits are the ones truncated.
- y, input, WIDTH, unsigned multiplier.
- level, input, LW, requested truncation level L.
- comp_en, input, 1, add the compensation term.
- out_valid, output, 1, result valid.
- out_ready, input, 1, consumer accepts the result.
- z, output, 2*WIDTH, approximate product.
- level_used, output, LW, effective L after clamping, returned with z.

Behaviour:
- Reset, asynchronous on rst_n low: all stage valid bits = 0, out_valid = 0, z = 0, level_used = 0.
  - in_ready = 1 from the first cycle after rst_n deasserts.
  - Asserting rst_n mid-operation discards every in-flight transaction; no partial result is ever presented.
- Transfer rules:
  - An input transfer occurs when in_valid && in_ready at a rising edge.
  - An output transfer occurs when out_valid && out_ready.
- Effective level: Le = min(level, LMAX), clamped at stage 1. Le travels with its data.
- Arithmetic, all unsigned, with no overflow possible in 2*WIDTH bits:
  - xt = x >> Le
  - base = (y * xt) << Le
  - comp = 2^(Le+3) when comp_en && Le >= 4 && x[2] && x[3] && y[Le] && y[Le-1]; otherwise comp = 0.
  - z = base + comp, truncated to 2*WIDTH bits. The sum cannot wrap for legal parameters.
  - Le = 0 gives the exact product; comp is ignored.
- Pipeline, 3 stages, latency exactly 3 cycles from input transfer to out_valid with no stall:
  - S1 registers xt, y, Le and the comp bit, all computed combinationally from the inputs.
  - S2 registers the two half products: plo = y * xt[WIDTH/2-1:0] and phi = y * xt[WIDTH-1:WIDTH/2].
  - S3 registers z = ((phi << WIDTH/2) + plo) << Le, plus comp, and registers level_used.
- Backpressure:
  - The pipeline advances when !out_valid || out_ready.
  - in_ready = !out_valid || out_ready, driven combinationally from the S3 state; this is the global stall.
  - While stalled, z, level_used and out_valid hold stable, and all stage registers hold.
  - No bubbles are inserted and none are collapsed. Throughput is 1 per cycle when out_ready stays high.
  - Results leave in strict input order.
- Simultaneous events: an S3 result leaving and a new input entering in the same cycle is legal and loses no data.
- Outputs are registered, except in_ready, which is combinational from out_valid and out_ready only. There is no combinational path from in_valid to out_valid.

Test Plan:
- Exact mode: L=0, x=y=0xFFFFFFFF, comp_en=1 -> z=0xFFFFFFFE00000001 and level_used=0, out_valid exactly 3 cycles after the transfer.
- Truncation: L=10, x=0xFFFFFFFF, y=1, comp_en=0 -> z=0x00000000FFFFFC00.
- Compensation: L=10, x=0x0000000C, y=0x00000600.
  - comp_en=1 -> z=0x2000.
  - comp_en=0 -> z=0.
- Clamp: level=31, LMAX=16, x=0x00012345, y=3 -> level_used=16, z=3*(0x1<<16)=0x30000.
- Backpressure and ordering: stream 8 back-to-back random requests while out_ready toggles 1,0,0,1,…
  - All 8 results arrive in order and match the golden model.
  - z stays stable during stalls.
  - in_ready is low exactly when out_valid && !out_ready.
- Reset mid-flight: 2 requests in flight, pulse rst_n low for half a cycle -> out_valid=0 immediately and no stale result afterwards; a subsequent request yields the correct result 3 cycles later.

Source files
------------

// File: rtl/approx_umult_pipe_if.sv
// Request/response bundle for approx_umult_pipe: valid/ready on both sides,
// operands and level on the request side, product and level echo on the result side.
interface approx_umult_pipe_if #(
  parameter int WIDTH = 32,
  parameter int LW    = 5
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     x;
  logic [WIDTH-1:0]     y;
  logic [LW-1:0]        level;
  logic                 comp_en;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   z;
  logic [LW-1:0]        level_used;

  modport master (
    output in_valid, x, y, level, comp_en, out_ready,
    input  in_ready, out_valid, z, level_used
  );

  modport slave (
    input  in_valid, x, y, level, comp_en, out_ready,
    output in_ready, out_valid, z, level_used
  );
endinterface

// File: rtl/approx_umult_pipe.sv
// Three-stage truncated approximate unsigned multiplier with a run-time
// truncation level, an optional compensation term and a global-stall
// valid/ready pipeline.
module approx_umult_pipe #(
  parameter int WIDTH = 32,
  parameter int LMAX  = 16,
  parameter int LW    = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  approx_umult_pipe_if.slave bus
);

  localparam int H  = WIDTH / 2;
  localparam int PW = 2 * WIDTH;
  localparam int HW = WIDTH + H;

  logic              advance;

  // stage 1 combinational inputs
  logic [LW-1:0]     le_c;
  logic [WIDTH-1:0]  xt_c;
  logic              comp_c;

  // stage registers
  logic              s1_valid;
  logic [WIDTH-1:0]  s1_xt;
  logic [WIDTH-1:0]  s1_y;
  logic [LW-1:0]     s1_le;
  logic              s1_comp;

  logic              s2_valid;
  logic [HW-1:0]     s2_plo;
  logic [HW-1:0]     s2_phi;
  logic [LW-1:0]     s2_le;
  logic              s2_comp;

  logic              out_valid_q;
  logic [PW-1:0]     z_q;
  logic [LW-1:0]     lu_q;

  // stage 3 combinational result
  logic [PW-1:0]     sum_c;
  logic [PW-1:0]     z_c;

  // The whole pipeline moves together; only the output stage can block it.
  assign advance      = !out_valid_q || bus.out_ready;
  assign bus.in_ready = advance;

  assign bus.out_valid  = out_valid_q;
  assign bus.z          = z_q;
  assign bus.level_used = lu_q;

  // Clamp the level, shift off the truncated multiplicand bits, decide compensation.
  always_comb begin
    le_c   = (bus.level > LW'(LMAX)) ? LW'(LMAX) : bus.level;
    xt_c   = bus.x >> le_c;
    comp_c = 1'b0;
    if (bus.comp_en && (le_c >= LW'(4)))
      comp_c = bus.x[2] & bus.x[3] & bus.y[le_c] & bus.y[le_c - 1'b1];
  end

  // Recombine half products, restore the truncated weight, add compensation.
  always_comb begin
    sum_c = (PW'(s2_phi) << H) + PW'(s2_plo);
    z_c   = (sum_c << s2_le)
          + (s2_comp ? (PW'(1) << (32'(s2_le) + 32'd3)) : '0);
  end

  // Pipeline registers; every stage holds while the output is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s1_xt       <= '0;
      s1_y        <= '0;
      s1_le       <= '0;
      s1_comp     <= 1'b0;
      s2_valid    <= 1'b0;
      s2_plo      <= '0;
      s2_phi      <= '0;
      s2_le       <= '0;
      s2_comp     <= 1'b0;
      out_valid_q <= 1'b0;
      z_q         <= '0;
      lu_q        <= '0;
    end else if (advance) begin
      s1_valid    <= bus.in_valid;
      s1_xt       <= xt_c;
      s1_y        <= bus.y;
      s1_le       <= le_c;
      s1_comp     <= comp_c;

      s2_valid    <= s1_valid;
      s2_plo      <= HW'(s1_y) * HW'(s1_xt[H-1:0]);
      s2_phi      <= HW'(s1_y) * HW'(s1_xt[WIDTH-1:H]);
      s2_le       <= s1_le;
      s2_comp     <= s1_comp;

      out_valid_q <= s2_valid;
      z_q         <= z_c;
      lu_q        <= s2_le;
    end
  end

endmodule

// File: tb/tb_approx_umult_pipe.sv
// Directed bench for approx_umult_pipe: the driver queues hand-computed
// expectations, a negedge monitor pops and compares each accepted result.
module tb_approx_umult_pipe;

  typedef struct packed {
    logic [63:0] z;
    logic [4:0]  lu;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  exp_t q[$];
  logic bp_mode = 1'b0;

  approx_umult_pipe_if #(.WIDTH(32), .LW(5)) bus ();

  approx_umult_pipe #(.WIDTH(32), .LMAX(16), .LW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, act, exp);
    end
  endtask

  // out_ready: held high, or cycled 1,0,0,1 while backpressure is exercised
  initial begin
    logic [3:0]  pat;
    int unsigned idx;
    pat = 4'b1001;
    idx = 0;
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode) begin
        bus.out_ready = pat[idx];
        idx = (idx + 1) % 4;
      end else begin
        bus.out_ready = 1'b1;
      end
    end
  end

  // monitor: handshake rule, stall stability, in-order scoreboard
  initial begin
    logic        hold_chk;
    logic [63:0] held_z;
    logic [4:0]  held_lu;
    exp_t        e;
    hold_chk = 1'b0;
    held_z   = '0;
    held_lu  = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("in_ready_rule", 64'(bus.in_ready), 64'(!(bus.out_valid && !bus.out_ready)));
        if (hold_chk) begin
          chk("stall_valid", 64'(bus.out_valid), 64'd1);
          chk("stall_z", bus.z, held_z);
          chk("stall_lu", 64'(bus.level_used), 64'(held_lu));
        end
        if (bus.out_valid && bus.out_ready) begin
          if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_output: got z=%h expected no result", bus.z);
          end else begin
            e = q.pop_front();
            chk("z", bus.z, e.z);
            chk("level_used", 64'(bus.level_used), 64'(e.lu));
          end
        end
        hold_chk = bus.out_valid && !bus.out_ready;
        held_z   = bus.z;
        held_lu  = bus.level_used;
      end else begin
        hold_chk = 1'b0;
      end
    end
  end

  // Present one request starting at posedge+1; returns at posedge+1 after the transfer.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [4:0] lv,
                      input logic c, input logic [63:0] ez, input logic [4:0] elu);
    int unsigned tries;
    logic        acc;
    exp_t        e;
    tries = 0;
    acc   = 1'b0;
    bus.x = a;
    bus.y = b;
    bus.level = lv;
    bus.comp_en = c;
    bus.in_valid = 1'b1;
    while (!acc && tries < 50) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      if (acc) begin
        e.z  = ez;
        e.lu = elu;
        q.push_back(e);
      end
      #1;
      tries++;
    end
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got no in_ready expected acceptance");
    end
    bus.in_valid = 1'b0;
  endtask

  // Counts rising edges from the transfer edge (inclusive) until out_valid shows.
  task automatic check_latency();
    int n;
    n = 1;
    while (!bus.out_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", 64'(n), 64'd3);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || bus.out_valid) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_timeout", 64'(n < 100), 64'd1);
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.x        = '0;
    bus.y        = '0;
    bus.level    = '0;
    bus.comp_en  = 1'b0;

    #12;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_z", bus.z, 64'd0);
    chk("rst_level_used", 64'(bus.level_used), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // exact mode, compensation ignored at L=0
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 1'b1, 64'hFFFF_FFFE_0000_0001, 5'd0);
    check_latency();
    drain();

    // truncation, compensation on/off, clamp
    send(32'hFFFF_FFFF, 32'h0000_0001, 5'd10, 1'b0, 64'h0000_0000_FFFF_FC00, 5'd10);
    send(32'h0000_000C, 32'h0000_0600, 5'd10, 1'b1, 64'h0000_0000_0000_2000, 5'd10);
    send(32'h0000_000C, 32'h0000_0600, 5'd10, 1'b0, 64'h0000_0000_0000_0000, 5'd10);
    send(32'h0001_2345, 32'h0000_0003, 5'd31, 1'b0, 64'h0000_0000_0003_0000, 5'd16);
    drain();

    // back-to-back stream under 1,0,0,1 backpressure
    bp_mode = 1'b1;
    send(32'h0000_0005, 32'h0000_0007, 5'd0,  1'b0, 64'h0000_0000_0000_0023, 5'd0);
    send(32'h0000_0100, 32'h0000_0010, 5'd4,  1'b0, 64'h0000_0000_0000_1000, 5'd4);
    send(32'h0000_01FF, 32'h0000_0002, 5'd8,  1'b0, 64'h0000_0000_0000_0200, 5'd8);
    send(32'h0000_000C, 32'h0000_0018, 5'd4,  1'b1, 64'h0000_0000_0000_0080, 5'd4);
    send(32'h0000_FFFF, 32'h0001_0001, 5'd0,  1'b0, 64'h0000_0000_FFFF_FFFF, 5'd0);
    send(32'hFFFF_0000, 32'hFFFF_0000, 5'd16, 1'b0, 64'hFFFE_0001_0000_0000, 5'd16);
    send(32'h0000_300C, 32'h0000_1800, 5'd12, 1'b1, 64'h0000_0000_0480_8000, 5'd12);
    send(32'h0002_0000, 32'h0000_0100, 5'd20, 1'b0, 64'h0000_0000_0200_0000, 5'd16);
    drain();
    bp_mode = 1'b0;
    @(posedge clk);
    #1;

    // reset with two requests in flight
    send(32'h0000_FFFF, 32'h0000_FFFF, 5'd0, 1'b0, 64'h0000_0000_FFFE_0001, 5'd0);
    send(32'h0000_0009, 32'h0000_0009, 5'd0, 1'b0, 64'h0000_0000_0000_0051, 5'd0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    q.delete();
    #4;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk("no_stale_valid", 64'(bus.out_valid), 64'd0);
    end
    send(32'h0000_0007, 32'h0000_0006, 5'd0, 1'b0, 64'h0000_0000_0000_002A, 5'd0);
    check_latency();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
